// File: rtl/axi_pkg.sv
// ---------------------------------------------------------------------------
// axi_pkg
//   Shared definitions for the AXI read/write decoders:
//   - RRESP/BRESP codes used by the decoders
//   - slave-select enum produced by the address decoder
//   - read-decoder FSM state enum
//   - default address map (two 64 KiB regions)
// ---------------------------------------------------------------------------
package axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        SEL_S0,
        SEL_S1,
        SEL_DEFAULT
    } sel_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_DERR
    } rd_state_e;

    localparam logic [31:0] S0_BASE_DEF = 32'h0000_0000;
    localparam logic [31:0] S1_BASE_DEF = 32'h0001_0000;
    localparam logic [31:0] REGION_SIZE = 32'h0001_0000;
    localparam logic [31:0] REGION_MASK = REGION_SIZE - 32'd1;

endpackage

// File: rtl/axi_addr_decode.sv
// ---------------------------------------------------------------------------
// axi_addr_decode
//   Pure combinational address decoder: maps an address onto one of two
//   64 KiB slave regions or onto the internal default (DECERR) slave.
//   Shared by the read- and write-path decoders.
// Ports:
//   addr  in   ADDR_W  address to decode
//   sel   out  sel_e   SEL_S0 / SEL_S1 / SEL_DEFAULT
// ---------------------------------------------------------------------------
module axi_addr_decode
    import axi_pkg::*;
#(
    parameter int                ADDR_W  = 32,
    parameter logic [ADDR_W-1:0] S0_BASE = ADDR_W'(S0_BASE_DEF),
    parameter logic [ADDR_W-1:0] S1_BASE = ADDR_W'(S1_BASE_DEF)
) (
    input  logic [ADDR_W-1:0] addr,
    output sel_e              sel
);

    localparam logic [ADDR_W-1:0] MASK = ADDR_W'(REGION_MASK);

    // Offset form avoids computing base+size, which could wrap for a region
    // placed at the very top of the address space.
    function automatic logic in_region(input logic [ADDR_W-1:0] a,
                                       input logic [ADDR_W-1:0] base);
        return (a >= base) && ((a - base) <= MASK);
    endfunction

    always_comb begin
        sel = SEL_DEFAULT;
        if (in_region(addr, S0_BASE)) begin
            sel = SEL_S0;
        end else if (in_region(addr, S1_BASE)) begin
            sel = SEL_S1;
        end
    end

endmodule

// File: rtl/axi_read_decoder.sv
// ---------------------------------------------------------------------------
// axi_read_decoder
//   One-master to two-slave AXI read-path decoder with an internal default
//   slave. One outstanding read at a time.
//   IDLE : accept AR from the master, latch payload, decode address.
//   ADDR : present registered AR to the selected slave until it is accepted.
//   DATA : combinational R pass-through from the selected slave until RLAST.
//   DERR : unmapped address; generate ARLEN+1 DECERR beats internally.
// Ports:
//   ACLK, ARESETn                        clock, async active-low reset
//   ARID_M/ARADDR_M/ARLEN_M/ARVALID_M    master AR in,  ARREADY_M out
//   RID_M/RDATA_M/RRESP_M/RLAST_M/RVALID_M  master R out, RREADY_M in
//   ARID_S/ARADDR_S/ARLEN_S              registered AR payload to both slaves
//   ARVALID_S0/1 out, ARREADY_S0/1 in    per-slave AR handshake
//   RID/RDATA/RRESP/RLAST/RVALID_S0/1 in, RREADY_S0/1 out  per-slave R
// ---------------------------------------------------------------------------
module axi_read_decoder
    import axi_pkg::*;
#(
    parameter int                ID_W    = 8,
    parameter int                ADDR_W  = 32,
    parameter int                DATA_W  = 32,
    parameter logic [ADDR_W-1:0] S0_BASE = ADDR_W'(S0_BASE_DEF),
    parameter logic [ADDR_W-1:0] S1_BASE = ADDR_W'(S1_BASE_DEF)
) (
    input  logic              ACLK,
    input  logic              ARESETn,
    // master AR
    input  logic [ID_W-1:0]   ARID_M,
    input  logic [ADDR_W-1:0] ARADDR_M,
    input  logic [7:0]        ARLEN_M,
    input  logic              ARVALID_M,
    output logic              ARREADY_M,
    // master R
    output logic [ID_W-1:0]   RID_M,
    output logic [DATA_W-1:0] RDATA_M,
    output logic [1:0]        RRESP_M,
    output logic              RLAST_M,
    output logic              RVALID_M,
    input  logic              RREADY_M,
    // slave AR (payload shared)
    output logic [ID_W-1:0]   ARID_S,
    output logic [ADDR_W-1:0] ARADDR_S,
    output logic [7:0]        ARLEN_S,
    output logic              ARVALID_S0,
    input  logic              ARREADY_S0,
    output logic              ARVALID_S1,
    input  logic              ARREADY_S1,
    // slave 0 R
    input  logic [ID_W-1:0]   RID_S0,
    input  logic [DATA_W-1:0] RDATA_S0,
    input  logic [1:0]        RRESP_S0,
    input  logic              RLAST_S0,
    input  logic              RVALID_S0,
    output logic              RREADY_S0,
    // slave 1 R
    input  logic [ID_W-1:0]   RID_S1,
    input  logic [DATA_W-1:0] RDATA_S1,
    input  logic [1:0]        RRESP_S1,
    input  logic              RLAST_S1,
    input  logic              RVALID_S1,
    output logic              RREADY_S1
);

    rd_state_e         state_reg, state_next;
    sel_e              sel_reg;
    sel_e              dec_sel;
    logic [ID_W-1:0]   id_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [7:0]        len_reg;
    logic [7:0]        cnt_reg;   // DECERR beats still to send after the current one
    logic              ar_accept;
    logic              derr_hs;

    axi_addr_decode #(
        .ADDR_W  (ADDR_W),
        .S0_BASE (S0_BASE),
        .S1_BASE (S1_BASE)
    ) u_addr_decode (
        .addr (ARADDR_M),
        .sel  (dec_sel)
    );

    assign ar_accept = (state_reg == ST_IDLE) && ARVALID_M;
    assign derr_hs   = (state_reg == ST_DERR) && RREADY_M;

    assign ARID_S   = id_reg;
    assign ARADDR_S = addr_reg;
    assign ARLEN_S  = len_reg;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_reg <= ST_IDLE;
            sel_reg   <= SEL_S0;
            id_reg    <= '0;
            addr_reg  <= '0;
            len_reg   <= '0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            if (ar_accept) begin
                id_reg   <= ARID_M;
                addr_reg <= ARADDR_M;
                len_reg  <= ARLEN_M;
                sel_reg  <= dec_sel;
                // Counting down from ARLEN to 0 gives ARLEN+1 beats in 8 bits,
                // so a 256-beat burst needs no wider counter.
                cnt_reg  <= ARLEN_M;
            end else if (derr_hs && (cnt_reg != 8'd0)) begin
                cnt_reg <= cnt_reg - 8'd1;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        ARREADY_M  = 1'b0;
        ARVALID_S0 = 1'b0;
        ARVALID_S1 = 1'b0;
        RREADY_S0  = 1'b0;
        RREADY_S1  = 1'b0;
        RVALID_M   = 1'b0;
        RID_M      = '0;
        RDATA_M    = '0;
        RRESP_M    = RESP_OKAY;
        RLAST_M    = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                ARREADY_M = 1'b1;
                if (ARVALID_M) begin
                    state_next = (dec_sel == SEL_DEFAULT) ? ST_DERR : ST_ADDR;
                end
            end

            ST_ADDR: begin
                if (sel_reg == SEL_S1) begin
                    ARVALID_S1 = 1'b1;
                    if (ARREADY_S1) state_next = ST_DATA;
                end else begin
                    ARVALID_S0 = 1'b1;
                    if (ARREADY_S0) state_next = ST_DATA;
                end
            end

            ST_DATA: begin
                // The non-selected slave's R channel is ignored entirely and
                // its RREADY stays low.
                if (sel_reg == SEL_S1) begin
                    RVALID_M  = RVALID_S1;
                    RID_M     = RID_S1;
                    RDATA_M   = RDATA_S1;
                    RRESP_M   = RRESP_S1;
                    RLAST_M   = RLAST_S1;
                    RREADY_S1 = RREADY_M;
                end else begin
                    RVALID_M  = RVALID_S0;
                    RID_M     = RID_S0;
                    RDATA_M   = RDATA_S0;
                    RRESP_M   = RRESP_S0;
                    RLAST_M   = RLAST_S0;
                    RREADY_S0 = RREADY_M;
                end
                if (RVALID_M && RREADY_M && RLAST_M) begin
                    state_next = ST_IDLE;
                end
            end

            ST_DERR: begin
                RVALID_M = 1'b1;
                RID_M    = id_reg;
                RRESP_M  = RESP_DECERR;
                RLAST_M  = (cnt_reg == 8'd0);
                if (RREADY_M && (cnt_reg == 8'd0)) begin
                    state_next = ST_IDLE;
                end
            end

            default: state_next = ST_IDLE;
        endcase
    end

endmodule

// File: doc/axi_read_decoder.md
Name: axi_read_decoder

Overview:
- One-master-to-many-slave AXI read-path decoder: the opposite end of the two-master arbiter.
- Accepts one AR request from the arbitrated master side and decodes ARADDR to one of two slaves, or to an internal default slave.
- Forwards AR to the selected slave, then routes that slave's R burst back to the master until RLAST.
- Unmapped addresses get an internally generated DECERR burst. One outstanding read at a time.

Parameters:
- ID_W, 8, ARID/RID width
- ADDR_W, 32, address width
- DATA_W, 32, RDATA width
- S0_BASE, 32'h0000_0000, slave 0 base; region size 64 KiB
- S1_BASE, 32'h0001_0000, slave 1 base; region size 64 KiB

Ports:
- ACLK  in  1  clock
- ARESETn  in  1  asynchronous active-low reset
- ARID_M / ARADDR_M / ARLEN_M  in  ID_W / ADDR_W / 8  master AR payload
- ARVALID_M  in  1;  ARREADY_M  out  1  master AR handshake
- RID_M / RDATA_M / RRESP_M / RLAST_M  out  ID_W / DATA_W / 2 / 1  master R payload
- RVALID_M  out  1;  RREADY_M  in  1  master R handshake
- ARID_S / ARADDR_S / ARLEN_S  out  ID_W / ADDR_W / 8  registered AR payload, broadcast to both slaves
- ARVALID_S0, ARVALID_S1  out  1 each;  ARREADY_S0, ARREADY_S1  in  1 each
- RID_Sx / RDATA_Sx / RRESP_Sx / RLAST_Sx / RVALID_Sx  in  per slave x=0,1;  RREADY_Sx  out  1 each

Behaviour:
- Clocking/reset: single clock ACLK, asynchronous active-low reset ARESETn.
- Reset values:
  - State IDLE, all registers 0.
  - ARREADY_M=1 (IDLE), ARVALID_S0/1=0, RVALID_M=0, RREADY_S0/1=0.
  - RID_M/RDATA_M/RRESP_M/RLAST_M=0.
- States: IDLE, ADDR, DATA, DERR.
- IDLE:
  - ARREADY_M=1.
  - On ARVALID_M&&ARREADY_M: latch ID/ADDR/LEN, decode, register sel.
  - Next state is ADDR if mapped, DERR if unmapped.
- Decode:
  - S0 when ARADDR in [S0_BASE, S0_BASE+0xFFFF].
  - S1 when ARADDR in [S1_BASE, S1_BASE+0xFFFF].
  - Anything else is unmapped (DEFAULT).
  - Comparisons are unsigned at full ADDR_W.
- ADDR:
  - ARVALID_S{sel}=1 from registered payload, first asserted the cycle after master handshake (1-cycle AR latency).
  - ARVALID held stable until ARREADY_S{sel}; then go to DATA.
  - ARREADY_M=0.
- DATA: R is a combinational pass-through from slave sel.
  - RVALID_M=RVALID_S{sel}.
  - R payload muxed from sel.
  - RREADY_S{sel}=RREADY_M; the non-selected RREADY is 0.
  - On RVALID_M&&RREADY_M&&RLAST_M: go to IDLE.
  - Non-last beats stay in DATA.
  - Non-selected slave RVALID is ignored.
- DERR:
  - Beat counter loaded with ARLEN.
  - RVALID_M=1, RID_M=latched ID, RDATA_M=0, RRESP_M=2'b11 (DECERR), RLAST_M=(cnt==0).
  - Each R handshake decrements cnt.
  - Handshake with cnt==0 goes to IDLE.
  - ARLEN=255 yields 256 beats with no counter overflow.
- Stability: while RVALID_M=1 and RREADY_M=0, payload is held constant (inherent for pass-through; registered for DERR).
- Back-to-back: IDLE is re-entered the cycle after the final R handshake, so a new AR can be accepted that cycle. Minimum idle gap between bursts is 1 cycle.
- Reset mid-burst: immediate return to IDLE with reset values; no completion of the outstanding burst.
- RID is not checked against the latched ID; slave RID passes through unchanged.

Decomposition:
- Shared package (axi_pkg):
  - RESP codes OKAY=2'b00, DECERR=2'b11.
  - Slave-select enum {SEL_S0, SEL_S1, SEL_DEFAULT}.
  - Decoder state enum.
  - Address-map base/size constants.
- One sub-module, axi_addr_decode: pure combinational ARADDR to slave-select enum. Reused later by the write-path decoder.

Test Plan:
- ARADDR=0x0000_0100, ARLEN=3, S0 returns 4 beats 0xA0..0xA3 with RLAST on beat 4 -> ARVALID_S0 asserted 1 cycle after accept, ARVALID_S1 stays 0, master sees 4 beats OKAY, FSM back in IDLE next cycle.
- ARADDR=0x0001_0000 (exact S1 base), ARLEN=0, ARREADY_S1 delayed 3 cycles -> ARVALID_S1 held 3 cycles with stable payload, single beat routed from S1.
- ARADDR=0x0002_0000, ARLEN=2, ARID=0x5 -> no slave ARVALID, 3 beats RRESP=2'b11, RDATA=0, RID=0x5, RLAST only on beat 3.
- Same DECERR case with RREADY_M toggling 1,0,0,1,1 -> beats advance only on handshake, RLAST stable while stalled.
- During S0 burst, S1 drives RVALID_S1=1 with RDATA=0xDEAD -> never appears on master side, RREADY_S1 stays 0.
- ARESETn asserted mid S0 burst (after beat 2 of 4) -> all outputs return to reset values immediately; after release, a new AR to S1 completes normally.
